// File: rtl/pulse_period_mon_pkg.sv
// pulse_mon_pkg
//   Shared definitions for the pulse period monitor and the upstream
//   delay/pulse generator: FSM state encoding and default timing constants.
package pulse_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam int DEF_PERIOD   = 751;
  localparam int DEF_TOL      = 2;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_CBITS    = 10;
  localparam int DEF_PCBITS   = 16;

endpackage

// File: rtl/pulse_period_mon_if.sv
// pulse_period_mon_if
//   Bundles the pulse input, the clear strobe and the status outputs of the
//   pulse period monitor.
//   master : drives sig_in/clr, observes status (generator side / bench)
//   slave  : the monitor itself
//   Signals: sig_in, clr, locked, err_early, err_late,
//            pulse_cnt[PCBITS], last_ivl[CBITS]
interface pulse_period_mon_if
  import pulse_mon_pkg::*;
#(
  parameter int CBITS  = DEF_CBITS,
  parameter int PCBITS = DEF_PCBITS
);

  logic              sig_in;
  logic              clr;
  logic              locked;
  logic              err_early;
  logic              err_late;
  logic [PCBITS-1:0] pulse_cnt;
  logic [CBITS-1:0]  last_ivl;

  modport master (
    output sig_in, clr,
    input  locked, err_early, err_late, pulse_cnt, last_ivl
  );

  modport slave (
    input  sig_in, clr,
    output locked, err_early, err_late, pulse_cnt, last_ivl
  );

endinterface

// File: rtl/pulse_period_mon_ivl_counter.sv
// ivl_counter
//   Saturating CBITS-wide up-counter with synchronous zero, plus a compare
//   that fires when the *next* count would equal limit.
//   Ports: clk, rst (async, active-low), zero (sync clear),
//          limit[CBITS] compare value, count[CBITS], hit (count+1 == limit)
module ivl_counter #(
  parameter int CBITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic [CBITS-1:0] limit,
  output logic [CBITS-1:0] count,
  output logic             hit
);

  localparam logic [CBITS-1:0] MAXV = '1;

  function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v);
    return (v == MAXV) ? v : v + CBITS'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (zero) count <= '0;
    else           count <= sat_inc(count);
  end

  // Extra bit so count+1 cannot wrap back onto a small limit.
  assign hit = ({1'b0, count} + (CBITS + 1)'(1)) == {1'b0, limit};

endmodule

// File: rtl/pulse_period_mon.sv
// pulse_period_mon
//   Checks a periodic single-cycle pulse stream. Measures the interval between
//   pulses, locks after LOCK_CNT consecutive in-tolerance intervals, flags
//   early and missing pulses, and exports a pulse count and the last interval.
//   Ports: clk, rst (async, active-low)
//          bus.sig_in   pulse input
//          bus.clr      sync clear of counters, flags and FSM
//          bus.locked   high while locked
//          bus.err_early/err_late  interval error flags
//          bus.pulse_cnt accepted pulses, bus.last_ivl last measured interval
//   Build option PULSE_MON_STICKY_ERR_EN: error flags latch until clr/reset
//   instead of pulsing for one cycle.
module pulse_period_mon
  import pulse_mon_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int CBITS    = DEF_CBITS,
  parameter int PCBITS   = DEF_PCBITS
) (
  input logic               clk,
  input logic               rst,
  pulse_period_mon_if.slave bus
);

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] LIMIT    = CBITS'(PERIOD + TOL);
  localparam logic [CBITS:0]   EARLY_LO = (CBITS + 1)'(PERIOD - TOL);
  localparam logic [GBITS-1:0] GOOD_TGT = GBITS'(LOCK_CNT);

  if (TOL < 0 || TOL >= PERIOD) begin : g_bad_tol
    $error("pulse_period_mon: TOL must satisfy 0 <= TOL < PERIOD");
  end
  if (LOCK_CNT < 1) begin : g_bad_lock
    $error("pulse_period_mon: LOCK_CNT must be >= 1");
  end
  if (PERIOD + TOL > (2 ** CBITS) - 1) begin : g_bad_cbits
    $error("pulse_period_mon: PERIOD+TOL must fit in CBITS");
  end

  state_t            state_p0, state_p1;
  logic [GBITS-1:0]  good_p0, good_p1;
  logic [CBITS-1:0]  ivl;
  logic              ivl_hit;
  logic [CBITS:0]    interval;
  logic              pulse;
  logic              is_early;
  logic              in_range;
  logic              early_ev;
  logic              late_ev;
  logic [PCBITS-1:0] pulse_cnt_p1;
  logic [CBITS-1:0]  last_ivl_p1;
  logic              err_early_p1;
  logic              err_late_p1;

  ivl_counter #(.CBITS(CBITS)) u_ivl (
    .clk   (clk),
    .rst   (rst),
    .zero  (bus.sig_in | bus.clr),
    .limit (LIMIT),
    .count (ivl),
    .hit   (ivl_hit)
  );

  // clr wins over a coincident pulse.
  assign pulse    = bus.sig_in & ~bus.clr;
  assign interval = {1'b0, ivl} + (CBITS + 1)'(1);
  assign is_early = interval < EARLY_LO;
  assign in_range = !is_early && (interval <= {1'b0, LIMIT});

  // ---- stage p0: next state and interval events ----
  always_comb begin
    state_p0 = state_p1;
    good_p0  = good_p1;
    early_ev = 1'b0;
    late_ev  = 1'b0;
    if (bus.clr) begin
      state_p0 = ST_IDLE;
      good_p0  = '0;
    end else begin
      case (state_p1)
        ST_IDLE: begin
          if (bus.sig_in) begin
            state_p0 = ST_ACQ;
            good_p0  = '0;
          end
        end
        ST_ACQ: begin
          if (bus.sig_in) begin
            if (is_early) begin
              early_ev = 1'b1;
              good_p0  = '0;
            end else if (in_range) begin
              if (good_p1 == GOOD_TGT - GBITS'(1)) begin
                good_p0  = GOOD_TGT;
                state_p0 = ST_LOCK;
              end else begin
                good_p0 = good_p1 + GBITS'(1);
              end
            end
          end else if (ivl_hit) begin
            // A pulse on the last legal slot is good, so timeout only fires
            // when that slot passes empty.
            late_ev  = 1'b1;
            state_p0 = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (bus.sig_in) begin
            if (is_early) begin
              early_ev = 1'b1;
              good_p0  = '0;
              state_p0 = ST_ACQ;
            end
          end else if (ivl_hit) begin
            late_ev  = 1'b1;
            state_p0 = ST_IDLE;
          end
        end
        default: begin
          state_p0 = ST_IDLE;
          good_p0  = '0;
        end
      endcase
    end
  end

  // ---- stage p1: registered FSM and status ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1 <= ST_IDLE;
      good_p1  <= '0;
    end else begin
      state_p1 <= state_p0;
      good_p1  <= good_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_cnt_p1 <= '0;
      last_ivl_p1  <= '0;
      err_early_p1 <= 1'b0;
      err_late_p1  <= 1'b0;
    end else if (bus.clr) begin
      pulse_cnt_p1 <= '0;
      last_ivl_p1  <= '0;
      err_early_p1 <= 1'b0;
      err_late_p1  <= 1'b0;
    end else begin
      if (pulse) begin
        pulse_cnt_p1 <= pulse_cnt_p1 + PCBITS'(1);
        // The first pulse out of IDLE has no meaningful predecessor.
        if (state_p1 != ST_IDLE) last_ivl_p1 <= interval[CBITS-1:0];
      end
`ifdef PULSE_MON_STICKY_ERR_EN
      err_early_p1 <= err_early_p1 | early_ev;
      err_late_p1  <= err_late_p1 | late_ev;
`else
      err_early_p1 <= early_ev;
      err_late_p1  <= late_ev;
`endif
    end
  end

  assign bus.locked    = (state_p1 == ST_LOCK);
  assign bus.err_early = err_early_p1;
  assign bus.err_late  = err_late_p1;
  assign bus.pulse_cnt = pulse_cnt_p1;
  assign bus.last_ivl  = last_ivl_p1;

endmodule
